// File: rtl/rle_decoder.sv
// Run-length decoder: fetches compressed words one at a time, expands each run into
// a 1-bit pixel stream and writes packed 16-pixel words to sequential addresses.
module rle_decoder #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  total_pixels,
    input  logic [ADDR_W-1:0] out_base_addr,
    output logic              in_req,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        EXPAND,
        FLUSH,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic [DATA_W-1:0]   run_q, run_d;
    logic                pixel_q, pixel_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   packer_q, packer_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [DATA_W-1:0]   packed_w;
    logic                last_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            run_q     <= '0;
            pixel_q   <= 1'b0;
            idx_q     <= '0;
            packer_q  <= '0;
            addr_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            run_q     <= run_d;
            pixel_q   <= pixel_d;
            idx_q     <= idx_d;
            packer_q  <= packer_d;
            addr_q    <= addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        run_d     = run_q;
        pixel_d   = pixel_q;
        idx_d     = idx_q;
        packer_d  = packer_q;
        addr_d    = addr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        packed_w  = packer_q;
        packed_w[idx_q] = pixel_q;
        last_bit  = (idx_q == IDX_W'(DATA_W - 1));

        case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d    = total_pixels;
                    addr_d   = out_base_addr;
                    packer_d = '0;
                    idx_d    = '0;
                    state_d  = (total_pixels == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (in_valid) begin
                    pixel_d = in_data[DATA_W-1];
                    run_d   = {1'b0, in_data[DATA_W-2:0]} + DATA_W'(1);
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                run_d = run_q - DATA_W'(1);
                rem_d = rem_q - CNT_W'(1);
                // A full word is registered out here so it appears on the bus next cycle.
                if (last_bit) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = packed_w;
                    wr_addr_d = addr_q;
                    addr_d    = addr_q + ADDR_W'(1);
                    idx_d     = '0;
                    packer_d  = '0;
                end else begin
                    idx_d    = idx_q + IDX_W'(1);
                    packer_d = packed_w;
                end
                if (rem_q == CNT_W'(1)) begin
                    state_d = last_bit ? DONE : FLUSH;
                end else if (run_q == DATA_W'(1)) begin
                    state_d = FETCH;
                end
            end
            FLUSH: begin
                wr_en_d   = 1'b1;
                wr_data_d = packer_q;
                wr_addr_d = addr_q;
                addr_d    = addr_q + ADDR_W'(1);
                packer_d  = '0;
                idx_d     = '0;
                state_d   = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_req  = (state_q == FETCH);
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_rle_decoder.sv
// Bench for rle_decoder: a DMA responder feeds queued words, a monitor records writes,
// requests and done pulses, and results are compared to a table and a pixel-level model.
module tb_rle_decoder;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int CNT_W  = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [CNT_W-1:0]  total_pixels;
    logic [ADDR_W-1:0] out_base_addr;
    logic              in_req;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    rle_decoder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .total_pixels  (total_pixels),
        .out_base_addr (out_base_addr),
        .in_req        (in_req),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .busy          (busy),
        .done          (done)
    );

    typedef struct {
        int               total;
        logic [15:0]      base;
        int               nWords;
        logic [3:0][15:0] words;
        int               nWr;
        logic [1:0][15:0] data;
        logic [1:0][15:0] addr;
        int               reqs;
        int               reqGap;
        bit               midStart;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] dmaWords[$];
    logic [15:0] wrAddrQ[$];
    logic [15:0] wrDataQ[$];
    logic [15:0] expAddrQ[$];
    logic [15:0] expDataQ[$];
    int          reqQ[$];
    int          expReqs;
    int          doneCount;
    int          doneNeg;
    int          lastStartNeg;
    int          negCycle = 0;
    int          underflow;
    bit          pendingReq = 1'b0;
    bit          timedOut;
    logic        busyAfter;

    // DMA model (data one cycle after each request) plus output recorder.
    always @(negedge clk) begin
        negCycle++;
        if (rst) begin
            pendingReq = 1'b0;
            in_valid   = 1'b0;
        end else begin
            in_valid = pendingReq;
            if (pendingReq) begin
                if (dmaWords.size() > 0) in_data = dmaWords.pop_front();
                else begin
                    in_data = '0;
                    underflow++;
                end
            end
            pendingReq = in_req;
            if (in_req) reqQ.push_back(negCycle);
            if (wr_en) begin
                wrAddrQ.push_back(wr_addr);
                wrDataQ.push_back(wr_data);
            end
            if (done) begin
                doneCount++;
                doneNeg = negCycle;
            end
            if (start && !busy) lastStartNeg = negCycle;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic clearRecords();
        wrAddrQ.delete();
        wrDataQ.delete();
        reqQ.delete();
        doneCount = 0;
        underflow = 0;
    endtask

    task automatic applyStimulus(input int total, input logic [15:0] base, input bit midStart);
        int guard;
        clearRecords();
        @(posedge clk); #1;
        start         = 1'b1;
        total_pixels  = CNT_W'(total);
        out_base_addr = base;
        @(posedge clk); #1;
        start = 1'b0;
        guard = 0;
        while (doneCount == 0 && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
            if (midStart && guard == 10) begin
                start         = 1'b1;
                total_pixels  = CNT_W'(5);
                out_base_addr = 16'h1234;
            end else begin
                start = 1'b0;
            end
        end
        start    = 1'b0;
        timedOut = (doneCount == 0);
        @(posedge clk); #1;
        busyAfter = busy;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic checkImage(input string tag);
        checkOutput({tag, ".timeout"}, 32'(timedOut), 32'd0);
        checkOutput({tag, ".writeCount"}, 32'(wrAddrQ.size()), 32'(expAddrQ.size()));
        for (int i = 0; i < wrAddrQ.size() && i < expAddrQ.size(); i++) begin
            checkOutput($sformatf("%s.wrAddr[%0d]", tag, i), 32'(wrAddrQ[i]), 32'(expAddrQ[i]));
            checkOutput($sformatf("%s.wrData[%0d]", tag, i), 32'(wrDataQ[i]), 32'(expDataQ[i]));
        end
        checkOutput({tag, ".reqCount"}, 32'(reqQ.size()), 32'(expReqs));
        checkOutput({tag, ".doneCount"}, 32'(doneCount), 32'd1);
        checkOutput({tag, ".busyAfter"}, 32'(busyAfter), 32'd0);
        checkOutput({tag, ".underflow"}, 32'(underflow), 32'd0);
    endtask

    // Reference: expand every run into a flat pixel list, then cut it into 16-pixel words.
    task automatic buildModel(input int total, input logic [15:0] base);
        bit          pix[$];
        int          wi = 0;
        int          run;
        logic [15:0] w;
        logic [15:0] d;
        expAddrQ.delete();
        expDataQ.delete();
        while (pix.size() < total && wi < dmaWords.size()) begin
            w = dmaWords[wi];
            wi++;
            run = int'(w[14:0]) + 1;
            for (int j = 0; j < run && pix.size() < total; j++) pix.push_back(w[15]);
        end
        expReqs = wi;
        for (int k = 0; k < (total + 15) / 16; k++) begin
            d = '0;
            for (int b = 0; b < 16; b++) begin
                if (k * 16 + b < total) d[b] = pix[k * 16 + b];
            end
            expAddrQ.push_back(base + 16'(k));
            expDataQ.push_back(d);
        end
    endtask

    vec_t vecs[6];

    initial begin
        int          total;
        int          sum;
        logic [15:0] base;
        logic [15:0] w;

        rst           = 1'b1;
        start         = 1'b0;
        total_pixels  = '0;
        out_base_addr = '0;
        in_valid      = 1'b0;
        in_data       = '0;

        vecs[0] = '{32, 16'h0100, 2, {16'h0, 16'h0, 16'h000F, 16'h800F}, 2, {16'h0000, 16'hFFFF}, {16'h0101, 16'h0100}, 2, 18, 1'b0};
        vecs[1] = '{20, 16'h0200, 1, {16'h0, 16'h0, 16'h0, 16'h8013}, 2, {16'h000F, 16'hFFFF}, {16'h0201, 16'h0200}, 1, 0, 1'b0};
        vecs[2] = '{3, 16'h0300, 3, {16'h0, 16'h8000, 16'h0000, 16'h8000}, 1, {16'h0, 16'h0005}, {16'h0, 16'h0300}, 3, 3, 1'b0};
        vecs[3] = '{16, 16'h0400, 1, {16'h0, 16'h0, 16'h0, 16'h7FFF}, 1, {16'h0, 16'h0000}, {16'h0, 16'h0400}, 1, 0, 1'b0};
        vecs[4] = '{32, 16'hFFFF, 1, {16'h0, 16'h0, 16'h0, 16'h801F}, 2, {16'hFFFF, 16'hFFFF}, {16'h0000, 16'hFFFF}, 1, 0, 1'b1};
        vecs[5] = '{0, 16'h0500, 0, {16'h0, 16'h0, 16'h0, 16'h0}, 0, {16'h0, 16'h0}, {16'h0, 16'h0}, 0, 0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.in_req", 32'(in_req), 32'd0);
        checkOutput("reset.wr_en", 32'(wr_en), 32'd0);
        checkOutput("reset.busy", 32'(busy), 32'd0);
        checkOutput("reset.done", 32'(done), 32'd0);
        checkOutput("reset.wr_addr", 32'(wr_addr), 32'd0);
        checkOutput("reset.wr_data", 32'(wr_data), 32'd0);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            dmaWords.delete();
            for (int i = 0; i < vecs[v].nWords; i++) dmaWords.push_back(vecs[v].words[i]);
            expAddrQ.delete();
            expDataQ.delete();
            for (int i = 0; i < vecs[v].nWr; i++) begin
                expAddrQ.push_back(vecs[v].addr[i]);
                expDataQ.push_back(vecs[v].data[i]);
            end
            expReqs = vecs[v].reqs;
            applyStimulus(vecs[v].total, vecs[v].base, vecs[v].midStart);
            checkImage($sformatf("vec%0d", v));
            if (vecs[v].reqGap != 0) begin
                for (int i = 1; i < reqQ.size(); i++)
                    checkOutput($sformatf("vec%0d.reqGap[%0d]", v, i), 32'(reqQ[i] - reqQ[i-1]), 32'(vecs[v].reqGap));
            end
            if (vecs[v].total == 0)
                checkOutput($sformatf("vec%0d.doneLatency", v), 32'(doneNeg - lastStartNeg), 32'd1);
        end

        // Reset in the middle of a run, five pixels in.
        dmaWords.delete();
        dmaWords.push_back(16'h801F);
        clearRecords();
        @(posedge clk); #1;
        start         = 1'b1;
        total_pixels  = CNT_W'(32);
        out_base_addr = 16'h0700;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midReset.busy", 32'(busy), 32'd0);
        checkOutput("midReset.in_req", 32'(in_req), 32'd0);
        checkOutput("midReset.wr_data", 32'(wr_data), 32'd0);
        @(posedge clk); #1;
        checkOutput("midReset.wr_en", 32'(wr_en), 32'd0);
        checkOutput("midReset.done", 32'(done), 32'd0);
        checkOutput("midReset.noWrites", 32'(wrAddrQ.size()), 32'd0);
        rst = 1'b0;
        dmaWords.delete();
        dmaWords.push_back(16'h800F);
        expAddrQ.delete();
        expDataQ.delete();
        expAddrQ.push_back(16'h0A00);
        expDataQ.push_back(16'hFFFF);
        expReqs = 1;
        applyStimulus(16, 16'h0A00, 1'b0);
        checkImage("afterReset");

        for (int r = 0; r < 20; r++) begin
            total = $urandom_range(0, 100);
            base  = 16'($urandom);
            dmaWords.delete();
            sum = 0;
            while (sum < total) begin
                if ($urandom_range(0, 9) == 0) w = {1'($urandom_range(0, 1)), 15'($urandom)};
                else w = {1'($urandom_range(0, 1)), 15'($urandom_range(0, 20))};
                dmaWords.push_back(w);
                sum += int'(w[14:0]) + 1;
            end
            dmaWords.push_back(16'h8003);
            dmaWords.push_back(16'h0003);
            buildModel(total, base);
            applyStimulus(total, base, 1'b0);
            checkImage($sformatf("rand%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
